// File: rtl/vm_pkg.sv
// Shared definitions for the parametrised vending controller:
// coin codes as presented by the front end and the controller state encoding.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_A    = 2'b01;
  localparam logic [1:0] COIN_B    = 2'b10;
  localparam logic [1:0] COIN_C    = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHANGE = 2'd1,
    REFUND = 2'd2
  } state_t;

endpackage

// File: rtl/vm_coin_value.sv
// Maps a coin code to its value in price units, one bit wider than the credit
// register so a credit+coin sum never needs to be truncated.
module vm_coin_value
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int COIN_A   = 1,
  parameter int COIN_B   = 2,
  parameter int COIN_C   = 5
) (
  input  logic [1:0]        coin,
  output logic [CREDIT_W:0] value
);

  // Local value parameters shadow the package names, so code constants are scoped explicitly.
  always_comb begin
    value = '0;
    case (coin)
      vm_pkg::COIN_A: value = (CREDIT_W+1)'(COIN_A);
      vm_pkg::COIN_B: value = (CREDIT_W+1)'(COIN_B);
      vm_pkg::COIN_C: value = (CREDIT_W+1)'(COIN_C);
      default:        value = '0;
    endcase
  end

endmodule

// File: rtl/vending_machine_param.sv
// Coin-operated vending controller: collects coins up to a credit limit, vends at
// PRICE, returns change or refunds one unit per cycle, and counts sales.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int COIN_A     = 1,
  parameter int COIN_B     = 2,
  parameter int COIN_C     = 5,
  parameter int MAX_CREDIT = 6,
  parameter int CREDIT_W   = 4,
  parameter int SALES_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [SALES_W-1:0]  sales_cnt
);

  localparam logic [CREDIT_W:0] PRICE_V = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_V   = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic [CREDIT_W:0]   value;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   rest;
  logic                coin_in;

  vm_coin_value #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B),
    .COIN_C   (COIN_C)
  ) u_coin_value (
    .coin  (coin),
    .value (value)
  );

  assign coin_in = (coin != COIN_NONE);
  assign sum     = {1'b0, credit} + value;
  assign rest    = sum - PRICE_V;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      credit       <= '0;
      sales_cnt    <= '0;
    end else begin
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        IDLE: begin
          // A refund takes priority; a coin arriving with it is handed straight back.
          if (cancel && (credit != '0)) begin
            state       <= REFUND;
            busy        <= 1'b1;
            coin_reject <= coin_in;
          end else if (coin_in) begin
            if (sum > MAX_V) begin
              coin_reject <= 1'b1;
            end else if (sum >= PRICE_V) begin
              dispense  <= 1'b1;
              sales_cnt <= sales_cnt + SALES_W'(1);
              credit    <= rest[CREDIT_W-1:0];
              if (rest != '0) begin
                state <= CHANGE;
                busy  <= 1'b1;
              end
            end else begin
              credit <= sum[CREDIT_W-1:0];
            end
          end
        end
        CHANGE, REFUND: begin
          change_pulse <= 1'b1;
          credit       <= credit - CREDIT_W'(1);
          coin_reject  <= coin_in;
          // busy drops together with the final unit returned.
          if (credit == CREDIT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: a transaction-level model predicts
// each cycle's outputs, a monitor compares them one edge later.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       dispense, change_pulse, coin_reject, busy;
  logic [3:0] credit;
  logic [7:0] sales_cnt;

  vending_machine_param dut (
    .clk          (clk),
    .rstn         (rstn),
    .coin         (coin),
    .cancel       (cancel),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .busy         (busy),
    .credit       (credit),
    .sales_cnt    (sales_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic       c;
    logic       r;
    logic       b;
    logic [3:0] cr;
    logic [7:0] s;
  } obs_t;

  obs_t q[$];
  obs_t mon_e, mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: credit, whether money is being paid back, and total sales.
  int   m_credit = 0;
  int   m_sales  = 0;
  bit   m_ret    = 0;
  int   coin_val[4] = '{0, 1, 2, 5};
  localparam int PRICE = 3;
  localparam int MAXC  = 6;

  task automatic step(input logic [1:0] c, input logic k);
    obs_t e;
    int   s;
    @(negedge clk);
    coin   = c;
    cancel = k;
    e = '0;
    if (m_ret) begin
      e.c = 1'b1;
      m_credit--;
      if (m_credit == 0) m_ret = 0;
      e.r = (c != 2'b00);
    end else if (k && m_credit > 0) begin
      m_ret = 1;
      e.r = (c != 2'b00);
    end else if (c != 2'b00) begin
      s = m_credit + coin_val[c];
      if (s > MAXC) begin
        e.r = 1'b1;
      end else if (s >= PRICE) begin
        e.d = 1'b1;
        m_sales = (m_sales + 1) % 256;
        m_credit = s - PRICE;
        m_ret = (m_credit > 0);
      end else begin
        m_credit = s;
      end
    end
    e.b  = m_ret;
    e.cr = m_credit[3:0];
    e.s  = m_sales[7:0];
    q.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if ({dispense, change_pulse, coin_reject, busy, credit, sales_cnt} !== 16'h0) begin
      n_bad++;
      $display("FAIL %s: got d%0b c%0b r%0b b%0b credit %0d sales %0d, want all 0",
               nm, dispense, change_pulse, coin_reject, busy, credit, sales_cnt);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rstn && q.size() > 0) begin
      mon_e = q.pop_front();
      mon_a = '{dispense, change_pulse, coin_reject, busy, credit, sales_cnt};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got d%0b c%0b r%0b b%0b cr%0d s%0d, want d%0b c%0b r%0b b%0b cr%0d s%0d",
                 $time, mon_a.d, mon_a.c, mon_a.r, mon_a.b, mon_a.cr, mon_a.s,
                 mon_e.d, mon_e.c, mon_e.r, mon_e.b, mon_e.cr, mon_e.s);
      end
    end
  end

  initial begin
    int guard;
    #3;
    chk_zero("reset_state");
    @(posedge clk);
    #2 rstn = 1'b1;

    // Directed scenarios.
    step(2'b01, 0); step(2'b10, 0); step(2'b00, 0);
    step(2'b11, 0); step(2'b00, 0); step(2'b00, 0); step(2'b00, 0);
    step(2'b10, 0); step(2'b11, 0); step(2'b00, 1); step(2'b00, 0); step(2'b00, 0); step(2'b00, 0);
    step(2'b11, 0); step(2'b01, 1); step(2'b00, 1); step(2'b00, 0);
    step(2'b01, 1); step(2'b10, 1); step(2'b00, 0); step(2'b00, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] c;
      logic       k;
      c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      k = ($urandom_range(0, 7) == 0);
      step(c, k);
    end

    // Drive sales up to 255, then one more vend to wrap.
    guard = 0;
    while ((m_sales != 255 || m_ret) && guard < 5000) begin
      if (m_ret) step(2'b00, 0);
      else if (m_credit + 5 > MAXC) step(2'b01, 0);
      else step(2'b11, 0);
      guard++;
    end
    while (m_sales == 255 && guard < 5000) begin
      if (m_credit + 5 > MAXC) step(2'b01, 0);
      else step(2'b11, 0);
      guard++;
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (sales_cnt !== 8'd0 || guard >= 5000) begin
      n_bad++;
      $display("FAIL sales_wrap: got %0d (guard %0d), want 0", sales_cnt, guard);
    end

    // Empty the machine, then reset in the middle of returning change.
    guard = 0;
    while ((m_ret || m_credit != 0) && guard < 50) begin
      step(2'b00, m_credit != 0 && !m_ret);
      guard++;
    end
    step(2'b11, 0);
    step(2'b00, 0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #2;
    chk_zero("reset_hold");
    rstn = 1'b1;
    m_credit = 0;
    m_ret    = 0;
    m_sales  = 0;
    for (int i = 0; i < 4; i++) step(2'b00, 0);
    step(2'b01, 0);
    step(2'b00, 0);
    @(posedge clk);
    #3;

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
